// File: rtl/b2o_encoder_pipe.sv
// Two-stage binary-to-onehot/thermometer encoder with offset and range check.
// Latency 2 cycles, full throughput; valid/ready on both sides, saturating monitor counters.
module b2o_encoder_pipe #(
  parameter int INPUT_W  = 6,
  parameter int OUTPUT_W = 64,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INPUT_W-1:0]  in_code,
  input  logic [INPUT_W-1:0]  cfg_offset,
  input  logic                cfg_thermo,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUTPUT_W-1:0] out_vec,
  output logic                out_oor,
  input  logic                cnt_clear,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    oor_count
);

  localparam logic [INPUT_W:0] OUT_LIM = (INPUT_W+1)'(OUTPUT_W);

  logic                a_valid;
  logic [INPUT_W-1:0]  a_diff;
  logic                a_under;
  logic                a_over;
  logic                a_thermo;

  logic [INPUT_W:0]    diff;
  logic                under;
  logic                over;
  logic                b_adv;
  logic                a_adv;
  logic                out_hs;
  logic [OUTPUT_W-1:0] enc;

  assign b_adv    = !out_valid || out_ready;
  assign a_adv    = !a_valid || b_adv;
  assign in_ready = a_adv;
  assign out_hs   = out_valid && out_ready;

  // One spare MSB keeps the subtraction borrow so the range compare is exact.
  assign diff  = {1'b0, in_code} - {1'b0, cfg_offset};
  assign under = in_code < cfg_offset;
  assign over  = !under && (diff >= OUT_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid  <= 1'b0;
      a_diff   <= '0;
      a_under  <= 1'b0;
      a_over   <= 1'b0;
      a_thermo <= 1'b0;
    end else if (a_adv) begin
      a_valid <= in_valid;
      if (in_valid) begin
        a_diff   <= diff[INPUT_W-1:0];
        a_under  <= under;
        a_over   <= over;
        a_thermo <= cfg_thermo;
      end
    end
  end

  always_comb begin
    enc = '0;
    if (a_over) begin
      enc = a_thermo ? '1 : '0;
    end else if (!a_under) begin
      for (int i = 0; i < OUTPUT_W; i++) begin
        enc[i] = a_thermo ? (INPUT_W'(i) <= a_diff) : (INPUT_W'(i) == a_diff);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_vec   <= '0;
      out_oor   <= 1'b0;
    end else if (b_adv) begin
      out_valid <= a_valid;
      if (a_valid) begin
        out_vec <= enc;
        out_oor <= a_under || a_over;
      end
    end
  end

  // Clear has priority over a same-cycle handshake, which is then not counted.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      hit_count <= '0;
      oor_count <= '0;
    end else if (out_hs) begin
      if (out_oor) begin
        if (oor_count != {CNT_W{1'b1}}) oor_count <= oor_count + 1'b1;
      end else begin
        if (hit_count != {CNT_W{1'b1}}) hit_count <= hit_count + 1'b1;
      end
    end
  end

endmodule
